// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter
// Two requesters share the 8-digit multiplexed 7-segment display. The owner
// keeps the grant for at least HOLD_FRAMES full scan frames unless it drops
// its request. The owner's value is saturated to 99_999_999, converted to
// 8 BCD digits by a sequential double-dabble (27 clk), and then scanned.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req0/val0          requester 0 request and 32-bit binary value
//   req1/val1          requester 1 request and 32-bit binary value
//   gnt0/gnt1          current display owner
//   an[7:0]            digit enables, active-low (bit i = digit i, 0 = LSD)
//   digit[3:0]         BCD nibble for the enabled digit (0 when blank)
//   busy               BCD conversion in progress
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   defined   -> digits above the most significant nonzero digit are blanked
//                (digit 0 is always shown)
//   undefined -> all 8 digits shown with leading zeros
module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] val0,
  input  logic        req1,
  input  logic [31:0] val1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  an,
  output logic [3:0]  digit,
  output logic        busy
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam logic [31:0] MAX_VAL = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] slot;
  logic [2:0]    idx;
  logic [FW-1:0] frames;
  logic [26:0]   bin_sr;
  logic [31:0]   bcd_sr;
  logic [4:0]    it_cnt;
  logic [31:0]   disp;
  logic          valid;

  logic          slot_end, frame_bnd, owned, gnt_chg, hold_done, latch;
  logic [31:0]   src_val;
  logic [26:0]   sat_val;
  logic [31:0]   bcd_adj, bcd_nxt;
  logic          shown;

  assign slot_end  = (slot == SW'(SCAN_DIV - 1));
  assign frame_bnd = slot_end && (idx == 3'd7);
  assign owned     = (state != IDLE);
  assign gnt_chg   = (state_nxt != state);
  assign hold_done = (frames == FW'(HOLD_FRAMES));
  assign gnt0      = (state == OWN0);
  assign gnt1      = (state == OWN1);

  // Scan timing: slot counter free-runs, index steps at slot end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      slot <= '0;
      idx  <= idx + 3'd1;
    end else begin
      slot <= slot + SW'(1);
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0)      state_nxt = OWN0;
        else if (req1) state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)                               state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && hold_done && frame_bnd) state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)                               state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && hold_done && frame_bnd) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frames owned, saturating; cleared on any grant change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 frames <= '0;
    else if (gnt_chg)                           frames <= '0;
    else if (owned && frame_bnd && !hold_done)  frames <= frames + FW'(1);
  end

  // Value of the owner-to-be, saturated to the 8-digit range.
  assign src_val = (state_nxt == OWN1) ? val1 : val0;
  assign sat_val = (src_val > MAX_VAL) ? MAX_VAL[26:0] : src_val[26:0];
  assign latch   = (state_nxt != IDLE) && (gnt_chg || (owned && frame_bnd));

  // Double-dabble step: add 3 to nibbles >= 5, then shift in next binary bit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int n = 0; n < 8; n++)
      if (bcd_sr[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_sr[4*n +: 4] + 4'd3;
    bcd_nxt = {bcd_adj[30:0], bin_sr[26]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      it_cnt <= '0;
      busy   <= 1'b0;
      disp   <= '0;
      valid  <= 1'b0;
    end else if (state_nxt == IDLE) begin
      // Losing the grant aborts any conversion and blanks the display.
      busy <= 1'b0;
      if (gnt_chg) valid <= 1'b0;
    end else if (latch) begin
      // Fresh data restarts the conversion; old digits stay up unless the
      // owner changed.
      bin_sr <= sat_val;
      bcd_sr <= '0;
      it_cnt <= '0;
      busy   <= 1'b1;
      if (gnt_chg) valid <= 1'b0;
    end else if (busy) begin
      bcd_sr <= bcd_nxt;
      bin_sr <= {bin_sr[25:0], 1'b0};
      it_cnt <= it_cnt + 5'd1;
      if (it_cnt == 5'd26) begin
        disp  <= bcd_nxt;
        valid <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++)
      if (disp[4*i +: 4] != 4'd0) msd = 3'(i);
  end
  assign shown = (idx <= msd);
`else
  assign shown = 1'b1;
`endif

  always_comb begin
    an    = 8'hFF;
    digit = 4'd0;
    if (owned && valid && shown) begin
      an    = ~(8'b1 << idx);
      digit = disp[{idx, 2'b00} +: 4];
    end
  end

endmodule
